// File: rtl/clkdiv_multi.sv
// Multi-channel glitch-free clock divider with runtime ratio and enable, both applied at period boundaries.
// Define CLKDIV_TICK_EN to add tick_o, a one-cycle pulse on each rising edge of dclk_o.
module clkdiv_ch #(
  parameter int DIV_W   = 8,
  parameter int DEF_DIV = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             oe_i,
  output logic             dclk_o,
`ifdef CLKDIV_TICK_EN
  output logic             tick_o,
`endif
  output logic             pend_o
);
  logic [DIV_W-1:0] cnt_q, cnt_d, div_act_q, div_act_d, div_pend_q, div_pend_d;
  logic [DIV_W-1:0] deff, deff_d;
  logic             pend_q, pend_d, oe_act_q, oe_act_d, dclk_q, dclk_d;
  logic             stop, wrap;

  // A ratio of 1 runs as 2 so the output always has a low phase.
  function automatic logic [DIV_W-1:0] eff(input logic [DIV_W-1:0] d);
    return (d == DIV_W'(1)) ? DIV_W'(2) : d;
  endfunction

  always_comb begin
    deff       = eff(div_act_q);
    stop       = (div_act_q == '0);
    wrap       = !stop && (cnt_q == deff - DIV_W'(1));
    cnt_d      = (stop || wrap) ? '0 : cnt_q + DIV_W'(1);
    div_act_d  = div_act_q;
    div_pend_d = div_pend_q;
    pend_d     = pend_q;
    oe_act_d   = oe_act_q;
    if (stop || wrap) begin
      oe_act_d = oe_i;
      if (pend_q) begin
        div_act_d = div_pend_q;
        pend_d    = 1'b0;
      end
    end
    // A write landing on a boundary cycle stays pending for the next one.
    if (wr_i) begin
      div_pend_d = div_i;
      pend_d     = 1'b1;
    end
    deff_d = eff(div_act_d);
    dclk_d = oe_act_d && (cnt_d < (deff_d >> 1));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      div_act_q  <= DIV_W'(DEF_DIV);
      div_pend_q <= '0;
      pend_q     <= 1'b0;
      oe_act_q   <= 1'b0;
      dclk_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_act_q  <= div_act_d;
      div_pend_q <= div_pend_d;
      pend_q     <= pend_d;
      oe_act_q   <= oe_act_d;
      dclk_q     <= dclk_d;
    end
  end

  assign dclk_o = dclk_q;
  assign pend_o = pend_q;

`ifdef CLKDIV_TICK_EN
  logic tick_q;
  // The high phase always starts at cnt==0, so that is the rising edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) tick_q <= 1'b0;
    else       tick_q <= dclk_d && (cnt_d == '0);
  end
  assign tick_o = tick_q;
`endif
endmodule

module clkdiv_multi #(
  parameter int NCH     = 4,
  parameter int CH_W    = 2,
  parameter int DIV_W   = 8,
  parameter int DEF_DIV = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cfg_wr_i,
  input  logic [CH_W-1:0]  cfg_ch_i,
  input  logic [DIV_W-1:0] cfg_div_i,
  input  logic [NCH-1:0]   oe_i,
  output logic [NCH-1:0]   dclk_o,
`ifdef CLKDIV_TICK_EN
  output logic [NCH-1:0]   tick_o,
`endif
  output logic [NCH-1:0]   pend_o
);
  // Channel indices >= NCH match no instance, so those writes fall away.
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    clkdiv_ch #(.DIV_W(DIV_W), .DEF_DIV(DEF_DIV)) u_ch (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .wr_i   (cfg_wr_i && (cfg_ch_i == CH_W'(c))),
      .div_i  (cfg_div_i),
      .oe_i   (oe_i[c]),
      .dclk_o (dclk_o[c]),
`ifdef CLKDIV_TICK_EN
      .tick_o (tick_o[c]),
`endif
      .pend_o (pend_o[c])
    );
  end
endmodule

// File: tb/tb_clkdiv_multi.sv
// Directed bench for clkdiv_multi: per-channel waveforms checked against hand-derived bit patterns.
module tb_clkdiv_multi;
  logic       clk = 1'b0, rst = 1'b1, wr = 1'b0;
  logic [2:0] ch = '0;
  logic [7:0] div = '0;
  logic [3:0] oe = '0, dclk, pend;
`ifdef CLKDIV_TICK_EN
  logic [3:0] tick;
`endif
  int n_chk = 0, n_err = 0;

  logic [3:0] ed [0:5] = '{4'h0, 4'hF, 4'h1, 4'hE, 4'h0, 4'hF};
  logic [3:0] ep [0:5] = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2};
  logic [3:0] et [0:5] = '{4'h0, 4'hF, 4'h0, 4'hE, 4'h0, 4'hF};

  clkdiv_multi #(.NCH(4), .CH_W(3), .DIV_W(8), .DEF_DIV(2)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .cfg_wr_i (wr),
    .cfg_ch_i (ch),
    .cfg_div_i(div),
    .oe_i     (oe),
    .dclk_o   (dclk),
`ifdef CLKDIV_TICK_EN
    .tick_o   (tick),
`endif
    .pend_o   (pend)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic cfg(input logic w, input logic [2:0] c, input logic [7:0] d);
    wr = w; ch = c; div = d;
  endtask

  // Holds reset across one edge, checks the cleared outputs, releases mid-cycle.
  task automatic do_rst(input string tag, input logic [3:0] o);
    rst = 1'b1; oe = o; cfg(1'b0, 3'd0, 8'd0);
    step();
    chk({tag, "_rst_dclk"}, {28'b0, dclk}, 32'h0);
    chk({tag, "_rst_pend"}, {28'b0, pend}, 32'h0);
`ifdef CLKDIV_TICK_EN
    chk({tag, "_rst_tick"}, {28'b0, tick}, 32'h0);
`endif
    rst = 1'b0;
  endtask

  // Pattern bit n-k is the expected value after edge k of the test (MSB = first edge).
  task automatic chk_ch(input string tag, input int c, input int k, input int n,
                        input logic [15:0] dp, input logic [15:0] pp);
    chk($sformatf("%s_dclk%0d", tag, k), {28'b0, dclk}, 32'(dp[n-k]) << c);
    chk($sformatf("%s_pend%0d", tag, k), {28'b0, pend}, 32'(pp[n-k]) << c);
  endtask

  initial begin
    do_rst("t1", 4'b0001);
    for (int k = 1; k <= 6; k++) begin
      step(); chk_ch("t1", 0, k, 6, 16'b010101, 16'b0);
    end

    do_rst("t2", 4'b0010);
    for (int k = 1; k <= 13; k++) begin
      step(); chk_ch("t2", 1, k, 13, 16'b0101011000110, 16'b0001100000000);
      if (k == 3) cfg(1'b1, 3'd1, 8'd5);
      if (k == 4) cfg(1'b0, 3'd0, 8'd0);
    end

    do_rst("t3", 4'b0001);
    cfg(1'b1, 3'd0, 8'd4);
    for (int k = 1; k <= 16; k++) begin
      step(); chk_ch("t3", 0, k, 16, 16'b0110011000000110, 16'b1000000000000000);
      if (k == 1)  cfg(1'b0, 3'd0, 8'd0);
      if (k == 6)  oe = 4'b0000;
      if (k == 11) oe = 4'b0001;
    end

    do_rst("t4", 4'b0100);
    for (int k = 1; k <= 13; k++) begin
      step(); chk_ch("t4", 2, k, 13, 16'b0100001001001, 16'b0010010000000);
      if (k == 2) cfg(1'b1, 3'd2, 8'd0);
      if (k == 3) cfg(1'b0, 3'd0, 8'd0);
      if (k == 5) cfg(1'b1, 3'd2, 8'd3);
      if (k == 6) cfg(1'b0, 3'd0, 8'd0);
    end

    do_rst("t5", 4'b1000);
    for (int k = 1; k <= 13; k++) begin
      step(); chk_ch("t5", 3, k, 13, 16'b0101111000011, 16'b0110000000000);
      if (k == 1) cfg(1'b1, 3'd3, 8'd6);
      if (k == 2) cfg(1'b1, 3'd3, 8'd8);
      if (k == 3) cfg(1'b1, 3'd5, 8'd3);
      if (k == 4) cfg(1'b0, 3'd0, 8'd0);
    end

    do_rst("t6", 4'b1111);
    cfg(1'b1, 3'd0, 8'd4);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("t6_dclk%0d", k), {28'b0, dclk}, {28'b0, ed[k-1]});
      chk($sformatf("t6_pend%0d", k), {28'b0, pend}, {28'b0, ep[k-1]});
`ifdef CLKDIV_TICK_EN
      chk($sformatf("t6_tick%0d", k), {28'b0, tick}, {28'b0, et[k-1]});
`endif
      if (k == 1) cfg(1'b0, 3'd0, 8'd0);
      if (k == 5) cfg(1'b1, 3'd1, 8'd7);
      if (k == 6) cfg(1'b0, 3'd0, 8'd0);
    end
    // Mid-period reset must clear outputs without waiting for an edge.
    #3 rst = 1'b1;
    #1;
    chk("t6_async_dclk", {28'b0, dclk}, 32'h0);
    chk("t6_async_pend", {28'b0, pend}, 32'h0);
`ifdef CLKDIV_TICK_EN
    chk("t6_async_tick", {28'b0, tick}, 32'h0);
`endif
    #1 rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("t6_post_dclk%0d", k), {28'b0, dclk}, (k % 2 == 0) ? 32'hF : 32'h0);
      chk($sformatf("t6_post_pend%0d", k), {28'b0, pend}, 32'h0);
`ifdef CLKDIV_TICK_EN
      chk($sformatf("t6_post_tick%0d", k), {28'b0, tick}, (k % 2 == 0) ? 32'hF : 32'h0);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
